// File: rtl/mem_bus_interface_pkg.sv
// Shared definitions for the memory-side bus stage: FSM state encoding,
// default bus width and the data word returned when an access times out.
package mem_bus_interface_pkg;

    localparam int          MB_XLEN     = 32;
    localparam logic [31:0] MB_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        MB_IDLE = 2'd0,
        MB_WAIT = 2'd1,
        MB_DONE = 2'd2
    } mb_state_e;

endpackage

// File: rtl/mem_bus_interface_timeout.sv
// Watchdog for the WAIT state: counts cycles since the access was issued
// and flags when the count reaches TIMEOUT.
module mem_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/mem_bus_interface.sv
// Memory-side stage of the bus datapath: issues one word access per enMem,
// waits for mem_ack (or a timeout), and presents read data on the bus in DONE.
module mem_bus_interface
    import mem_bus_interface_pkg::*;
#(
    parameter int               XLEN     = MB_XLEN,
    parameter int               ADDR_W   = 32,
    parameter int               TIMEOUT  = 255,
    parameter int               TO_W     = 8,
    parameter logic [XLEN-1:0]  ERR_DATA = XLEN'(MB_ERR_DATA)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enMem,
    input  logic              MemWrt,
    input  logic [ADDR_W-1:0] ma,
    input  logic [XLEN-1:0]   bus_in,
    output logic              busy,
    output logic [XLEN-1:0]   bus_out,
    output logic              bus_drive,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              misaligned,
    output logic              timeout_err,
    output mb_state_e         state_dbg
);

    mb_state_e         state_q, state_d;
    logic [ADDR_W-3:0] mem_addr_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [XLEN-1:0]   bus_out_q;
    logic              misaligned_q;
    logic              timeout_err_q;
    logic              issue;
    logic              expired;

    assign issue = (state_q == MB_IDLE) && enMem;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (issue),
        .enable  (state_q == MB_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_ack wins over an expiry landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MB_IDLE: if (enMem) state_d = MB_WAIT;
            MB_WAIT: if (mem_ack || expired) state_d = MB_DONE;
            MB_DONE: state_d = MB_IDLE;
            default: state_d = MB_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state_q == MB_WAIT);
        busy      = enMem && (state_q != MB_DONE);
        bus_drive = (state_q == MB_DONE) && enMem && !mem_we_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            bus_out_q     <= '0;
            misaligned_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (issue) begin
                mem_addr_q  <= ma[ADDR_W-1:2];
                mem_we_q    <= MemWrt;
                mem_wdata_q <= bus_in;
                if (ma[1:0] != 2'b00) misaligned_q <= 1'b1;
            end
            if (state_q == MB_WAIT) begin
                if (mem_ack) begin
                    if (!mem_we_q) bus_out_q <= mem_rdata;
                end else if (expired) begin
                    bus_out_q     <= ERR_DATA;
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign bus_out     = bus_out_q;
    assign misaligned  = misaligned_q;
    assign timeout_err = timeout_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scenario bench for mem_bus_interface: a scripted memory answers each request
// after a chosen delay, and expected read data is queued and popped on bus_drive.
module tb_mem_bus_interface;
    import mem_bus_interface_pkg::*;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        enMem;
    logic        MemWrt;
    logic [31:0] ma;
    logic [31:0] bus_in;
    logic        busy;
    logic [31:0] bus_out;
    logic        bus_drive;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        misaligned;
    logic        timeout_err;
    mb_state_e   state_dbg;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    mem_bus_interface #(
        .TIMEOUT (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enMem       (enMem),
        .MemWrt      (MemWrt),
        .ma          (ma),
        .bus_in      (bus_in),
        .busy        (busy),
        .bus_out     (bus_out),
        .bus_drive   (bus_drive),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .misaligned  (misaligned),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one access from the current negedge; ack_delay<=0 means memory never answers.
    task automatic run_access(input logic we, input logic [31:0] ma_v, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_delay, input logic hold,
                              output int busy_n, output int req_n, output int drive_n,
                              output int first_req);
        int wait_n;
        logic done;
        logic [31:0] exp_v;
        busy_n = 0; req_n = 0; drive_n = 0; first_req = 0; wait_n = 0; done = 1'b0;
        enMem = 1'b1; MemWrt = we; ma = ma_v; bus_in = wd; mem_rdata = rd; mem_ack = 1'b0;
        if (!we) exp_q.push_back((ack_delay > 0) ? rd : ERR);
        #1;
        if (busy) busy_n++;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (busy) busy_n++;
            if (mem_req) begin
                if (first_req == 0) first_req = cyc;
                req_n++;
                wait_n++;
                checks++;
                if (mem_addr !== ma_v[31:2] || mem_we !== we || mem_wdata !== wd) begin
                    failures++;
                    $display("FAIL req_fields: addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                             mem_addr, mem_we, mem_wdata, ma_v[31:2], we, wd);
                end
                MemWrt = ~we;
                bus_in = ~wd;
                if (wait_n == ack_delay) mem_ack = 1'b1;
            end
            if (state_dbg == MB_DONE) begin
                done = 1'b1;
                if (bus_drive) begin
                    drive_n++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL bus_data: got %h with nothing expected", bus_out);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (bus_out !== exp_v) begin
                            failures++;
                            $display("FAIL bus_data: got %h expected %h", bus_out, exp_v);
                        end
                    end
                end
                if (!hold) enMem = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_done: DONE not reached within 60 cycles, state=%0d", state_dbg);
            enMem = 1'b0;
        end else if (!hold) begin
            @(negedge clock);
            checks++;
            if (state_dbg !== MB_IDLE || mem_req !== 1'b0 || bus_drive !== 1'b0) begin
                failures++;
                $display("FAIL back_to_idle: state=%0d req=%b drive=%b expected IDLE 0 0",
                         state_dbg, mem_req, bus_drive);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enMem = 1'b0; MemWrt = 1'b0; ma = '0; bus_in = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (state_dbg !== MB_IDLE || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 30'd0 ||
            mem_wdata !== 32'd0 || bus_out !== 32'd0 || bus_drive !== 1'b0 || busy !== 1'b0 ||
            misaligned !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: state=%0d req=%b we=%b addr=%h wdata=%h out=%h drive=%b busy=%b mis=%b to=%b expected all zero",
                     state_dbg, mem_req, mem_we, mem_addr, mem_wdata, bus_out, bus_drive, busy,
                     misaligned, timeout_err);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_zero_wait_read();
        int b, r, d, f;
        run_access(1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 1'b0, b, r, d, f);
        checks++;
        if (b != 2 || r != 1 || d != 1 || f != 1) begin
            failures++;
            $display("FAIL zero_wait: busy=%0d req=%0d drive=%0d first=%0d expected 2 1 1 1", b, r, d, f);
        end
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL zero_wait_mis: got %b expected 0", misaligned);
        end
    endtask

    task automatic test_write_delay();
        int b, r, d, f;
        run_access(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h5555_5555, 3, 1'b0, b, r, d, f);
        checks++;
        if (b != 4 || r != 3 || d != 0) begin
            failures++;
            $display("FAIL write_delay: busy=%0d req=%0d drive=%0d expected 4 3 0", b, r, d);
        end
    endtask

    task automatic test_timeout();
        int b, r, d, f;
        run_access(1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 0, 1'b0, b, r, d, f);
        checks++;
        if (r != 5 || d != 1 || b != 6) begin
            failures++;
            $display("FAIL timeout_len: req=%0d drive=%0d busy=%0d expected 5 1 6", r, d, b);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag: got %b expected 1", timeout_err);
        end
    endtask

    task automatic test_misaligned();
        int b, r, d, f;
        run_access(1'b0, 32'h0000_0102, 32'h0, 32'hA5A5_0102, 2, 1'b0, b, r, d, f);
        checks++;
        if (misaligned !== 1'b1 || d != 1) begin
            failures++;
            $display("FAIL misaligned_set: mis=%b drive=%0d expected 1 1", misaligned, d);
        end
        run_access(1'b1, 32'h0000_0104, 32'h0BAD_F00D, 32'h0, 1, 1'b0, b, r, d, f);
        checks++;
        if (misaligned !== 1'b1 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL sticky_flags: mis=%b to=%b expected 1 1", misaligned, timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        int b, r, d1, f1, d2, f2;
        run_access(1'b0, 32'h0000_0400, 32'h0, 32'h0101_0101, 2, 1'b1, b, r, d1, f1);
        run_access(1'b0, 32'h0000_0404, 32'h0, 32'h0202_0202, 1, 1'b0, b, r, d2, f2);
        checks++;
        if (f1 != 1 || f2 != 2 || d1 != 1 || d2 != 1) begin
            failures++;
            $display("FAIL back_to_back: first_req=%0d/%0d drives=%0d/%0d expected 1/2 1/1", f1, f2, d1, d2);
        end
    endtask

    task automatic test_reset_in_wait();
        int b, r, d, f;
        enMem = 1'b1; MemWrt = 1'b0; ma = 32'h0000_0500; bus_in = 32'h0; mem_rdata = 32'h7777_7777;
        @(negedge clock);
        checks++;
        if (state_dbg !== MB_WAIT || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_pre: state=%0d req=%b expected WAIT 1", state_dbg, mem_req);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state_dbg !== MB_IDLE || mem_req !== 1'b0 || mem_addr !== 30'd0 ||
            misaligned !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: state=%0d req=%b addr=%h mis=%b to=%b expected IDLE 0 0 0 0",
                     state_dbg, mem_req, mem_addr, misaligned, timeout_err);
        end
        @(negedge clock);
        enMem = 1'b0;
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++;
        if (state_dbg !== MB_IDLE || bus_drive !== 1'b0 || bus_out !== 32'd0) begin
            failures++;
            $display("FAIL late_ack: state=%0d drive=%b out=%h expected IDLE 0 0", state_dbg, bus_drive, bus_out);
        end
        run_access(1'b0, 32'h0000_0600, 32'h0, 32'h600D_DA7A, 2, 1'b0, b, r, d, f);
        checks++;
        if (r != 2 || d != 1 || f != 1) begin
            failures++;
            $display("FAIL post_reset_access: req=%0d drive=%0d first=%0d expected 2 1 1", r, d, f);
        end
    endtask

    task automatic test_random();
        int b, r, d, f, dly;
        logic we;
        for (int i = 0; i < 6; i++) begin
            we  = 1'($urandom_range(0, 1));
            dly = $urandom_range(1, 3);
            run_access(we, {14'd0, 16'($urandom_range(0, 65535)), 2'b00}, $urandom, $urandom,
                       dly, 1'b0, b, r, d, f);
            checks++;
            if (r != dly || d != (we ? 0 : 1)) begin
                failures++;
                $display("FAIL random_access: req=%0d drive=%0d expected %0d %0d", r, d, dly, we ? 0 : 1);
            end
        end
        checks++;
        if (misaligned !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL flags_after_reset: mis=%b to=%b expected 0 0", misaligned, timeout_err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero_wait_read();
        test_write_delay();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d reads never reached the bus, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
